fmap_writer: RTL and testbench



---
 rtl/fmap_writer.sv | 149 ++++++++++++++
 tb/tb_fmap_writer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fmap_writer
// Purpose  : Feature-map writer for the first convolution layer. Takes one
//            vector of per-channel accumulators per output pixel, applies
//            ReLU, fixed-point rescale and saturation, and writes the result
//            to port A of a banked RAM (channel i -> bank i, shared address).
//            Sequences one frame of FRAME_LEN pixels per start pulse.
// Revision : 1.0 - initial release
// ============================================================================
module fmap_writer #(
    parameter int SIZE       = 32,
    parameter int WIDTH      = 16,
    parameter int ADDRESS    = 10,
    parameter int ACC_WIDTH  = 32,
    parameter int FRAC_SHIFT = 8,
    parameter int FRAME_LEN  = 1024,
    parameter bit RELU_EN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ACC_WIDTH-1:0] in_data [0:SIZE-1],
    output logic [SIZE-1:0]      ena,
    output logic [SIZE-1:0]      wea,
    output logic [ADDRESS-1:0]   addra   [0:SIZE-1],
    output logic [WIDTH-1:0]     dina    [0:SIZE-1],
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Index of the final pixel; the counter stops here instead of wrapping.
    localparam logic [ADDRESS-1:0] c_last = ADDRESS'(FRAME_LEN - 1);

    // Saturation bounds of a WIDTH-bit signed value, sign-extended to ACC_WIDTH.
    localparam logic signed [ACC_WIDTH-1:0] c_sat_max =
        {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_sat_min =
        {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    state_t               state_q, state_d;
    logic [ADDRESS-1:0]   cnt_q, cnt_d;
    logic                 we_q;
    logic [ADDRESS-1:0]   addr_q;
    logic [WIDTH-1:0]     dina_q [0:SIZE-1];
    logic [WIDTH-1:0]     dina_d [0:SIZE-1];
    logic                 accept;

    // Next-state, pixel counter and handshake/status outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                end
            end
            WRITE: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    if (cnt_q == c_last) begin
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-channel activation: optional ReLU, arithmetic rescale, saturation.
    for (genvar i = 0; i < SIZE; i++) begin : g_chan
        logic signed [ACC_WIDTH-1:0] w_shifted;
        assign w_shifted = $signed(in_data[i]) >>> FRAC_SHIFT;

        // Clamp to the representable WIDTH-bit signed range, then truncate.
        always_comb begin
            dina_d[i] = w_shifted[WIDTH-1:0];
            if (RELU_EN && in_data[i][ACC_WIDTH-1]) begin
                dina_d[i] = '0;
            end else if (w_shifted > c_sat_max) begin
                dina_d[i] = c_sat_max[WIDTH-1:0];
            end else if (w_shifted < c_sat_min) begin
                dina_d[i] = c_sat_min[WIDTH-1:0];
            end
        end
    end

    // State, counter and the one-cycle-delayed RAM write port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            for (int k = 0; k < SIZE; k++) begin
                dina_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= accept;
            if (accept) begin
                addr_q <= cnt_q;
                for (int k = 0; k < SIZE; k++) begin
                    dina_q[k] <= dina_d[k];
                end
            end
        end
    end

    assign ena = {SIZE{we_q}};
    assign wea = {SIZE{we_q}};

    // All banks share one address; data fans out per bank.
    for (genvar i = 0; i < SIZE; i++) begin : g_port
        assign addra[i] = addr_q;
        assign dina[i]  = dina_q[i];
    end

endmodule
`default_nettype wire

// File: tb/tb_fmap_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fmap_writer
// Purpose  : Self-checking bench for fmap_writer. Three instances cover the
//            full 1024-pixel frame with ReLU, a 16-pixel frame without ReLU,
//            and the single-pixel frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fmap_writer;

    localparam int SIZE      = 32;
    localparam int WIDTH     = 16;
    localparam int ADDRESS   = 10;
    localparam int ACC_WIDTH = 32;
    localparam int NV        = 10;

    typedef struct packed {
        logic [ADDRESS-1:0]           addr;
        logic [SIZE-1:0][WIDTH-1:0]   d;
    } exp_t;

    typedef struct {
        logic [ACC_WIDTH-1:0] acc;
        logic [WIDTH-1:0]     exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 in_valid;
    logic [2:0]           start_v;
    logic [ACC_WIDTH-1:0] in_data [0:SIZE-1];

    logic                 rdy_a, rdy_b, rdy_c, bsy_a, bsy_b, bsy_c, dn_a, dn_b, dn_c;
    logic [SIZE-1:0]      ena_a, wea_a, ena_b, wea_b, ena_c, wea_c;
    logic [ADDRESS-1:0]   addra_a [0:SIZE-1];
    logic [ADDRESS-1:0]   addra_b [0:SIZE-1];
    logic [ADDRESS-1:0]   addra_c [0:SIZE-1];
    logic [WIDTH-1:0]     dina_a  [0:SIZE-1];
    logic [WIDTH-1:0]     dina_b  [0:SIZE-1];
    logic [WIDTH-1:0]     dina_c  [0:SIZE-1];
    logic [2:0]           rdy, bsy, dn;

    assign rdy = {rdy_c, rdy_b, rdy_a};
    assign bsy = {bsy_c, bsy_b, bsy_a};
    assign dn  = {dn_c, dn_b, dn_a};

    fmap_writer #(.FRAME_LEN(1024), .RELU_EN(1'b1)) u_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(in_valid), .in_ready(rdy_a),
        .in_data(in_data), .ena(ena_a), .wea(wea_a), .addra(addra_a), .dina(dina_a),
        .busy(bsy_a), .done(dn_a));

    fmap_writer #(.FRAME_LEN(16), .RELU_EN(1'b0)) u_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(in_valid), .in_ready(rdy_b),
        .in_data(in_data), .ena(ena_b), .wea(wea_b), .addra(addra_b), .dina(dina_b),
        .busy(bsy_b), .done(dn_b));

    fmap_writer #(.FRAME_LEN(1), .RELU_EN(1'b1)) u_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .in_valid(in_valid), .in_ready(rdy_c),
        .in_data(in_data), .ena(ena_c), .wea(wea_c), .addra(addra_c), .dina(dina_c),
        .busy(bsy_c), .done(dn_c));

    vec_t tbl [2][NV];
    exp_t q0[$], q1[$], q2[$];
    exp_t last_e [3];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;
    bit   r0, r1, r2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s dut=%0d actual=%0h required=%0h t=%0t", nm, id, act, req, $time);
        end
    endtask

    function automatic logic [ACC_WIDTH-1:0] gen(input int mode, input int p, input int i);
        case (mode)
            0:       return 32'((p << 8) + i);
            1:       return tbl[0][(p + i) % NV].acc;
            default: return tbl[1][(p + i) % NV].acc;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] expv(input int mode, input int p, input int i);
        case (mode)
            0:       return 16'(p);
            1:       return tbl[0][(p + i) % NV].exp;
            default: return tbl[1][(p + i) % NV].exp;
        endcase
    endfunction

    function automatic void push(input int id, input exp_t e);
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int qsize(input int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop(input int id);
        case (id)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Scoreboard: every strobe must match the oldest expected write; idle
    // cycles must hold the last written address/data (zero after reset).
    task automatic mon(input int id, input bit was_rst, input logic [SIZE-1:0] en,
                       input logic [SIZE-1:0] we, input logic [ADDRESS-1:0] a [0:SIZE-1],
                       input logic [WIDTH-1:0] d [0:SIZE-1]);
        exp_t e;
        int   ia, id_;
        if (was_rst) last_e[id] = '0;
        chk("ena_eq_wea", id, 64'(en), 64'(we));
        e = last_e[id];
        if (we != '0) begin
            chk("strobe_all_banks", id, 64'(we == '1), 64'd1);
            chk("strobe_expected", id, 64'(qsize(id) > 0), 64'd1);
            if (qsize(id) > 0) begin
                e = pop(id);
                last_e[id] = e;
            end
        end
        ia = 0;
        id_ = 0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (a[i] !== e.addr) ia = i;
            if (d[i] !== e.d[i]) id_ = i;
        end
        chk("addra", id, 64'(a[ia]), 64'(e.addr));
        chk("dina", id, 64'(d[id_]), 64'(e.d[id_]));
    endtask

    always @(posedge clk) begin
        r0 = rst;
        #1;
        if (mon_en) mon(0, r0, ena_a, wea_a, addra_a, dina_a);
    end
    always @(posedge clk) begin
        r1 = rst;
        #1;
        if (mon_en) mon(1, r1, ena_b, wea_b, addra_b, dina_b);
    end
    always @(posedge clk) begin
        r2 = rst;
        #1;
        if (mon_en) mon(2, r2, ena_c, wea_c, addra_c, dina_c);
    end

    task automatic chk_rst(input int id);
        chk("rst_in_ready", id, 64'(rdy[id]), 64'd0);
        chk("rst_busy", id, 64'(bsy[id]), 64'd0);
        chk("rst_done", id, 64'(dn[id]), 64'd0);
        case (id)
            0: begin
                chk("rst_wea", id, 64'(wea_a), 64'd0);
                chk("rst_ena", id, 64'(ena_a), 64'd0);
                chk("rst_addra", id, 64'(addra_a[SIZE-1]), 64'd0);
                chk("rst_dina", id, 64'(dina_a[0]), 64'd0);
            end
            1: begin
                chk("rst_wea", id, 64'(wea_b), 64'd0);
                chk("rst_ena", id, 64'(ena_b), 64'd0);
                chk("rst_addra", id, 64'(addra_b[SIZE-1]), 64'd0);
                chk("rst_dina", id, 64'(dina_b[0]), 64'd0);
            end
            default: begin
                chk("rst_wea", id, 64'(wea_c), 64'd0);
                chk("rst_ena", id, 64'(ena_c), 64'd0);
                chk("rst_addra", id, 64'(addra_c[SIZE-1]), 64'd0);
                chk("rst_dina", id, 64'(dina_c[0]), 64'd0);
            end
        endcase
    endtask

    // One frame on instance id. Called and returning on a falling edge with
    // the instance idle. gap = percent of WRITE cycles without in_valid;
    // rst_at >= 0 aborts with reset on that pixel's beat; noise toggles start.
    task automatic run_frame(input int id, input int flen, input int mode, input int offs,
                             input int gap, input int rst_at, input bit noise);
        int   pix, t0, ngap, iter;
        bit   v;
        exp_t e;
        chk("idle_in_ready", id, 64'(rdy[id]), 64'd0);
        chk("idle_busy", id, 64'(bsy[id]), 64'd0);
        start_v[id] = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_v[id] = 1'b0;
        pix  = 0;
        ngap = 0;
        iter = 0;
        while (pix < flen) begin
            if (iter > flen * 20 + 20) begin
                chk("write_loop_bound", id, 64'(pix), 64'(flen));
                break;
            end
            iter++;
            chk("write_in_ready", id, 64'(rdy[id]), 64'd1);
            chk("write_busy", id, 64'(bsy[id]), 64'd1);
            chk("write_done", id, 64'(dn[id]), 64'd0);
            v = ($urandom_range(99) >= gap);
            if (noise) start_v[id] = ($urandom_range(1) == 1);
            in_valid = v;
            for (int i = 0; i < SIZE; i++) in_data[i] = v ? gen(mode, pix + offs, i) : $urandom;
            if (v && pix == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                in_valid = 1'b0;
                start_v[id] = 1'b0;
                chk_rst(id);
                chk("rst_queue_drained", id, 64'(qsize(id)), 64'd0);
                return;
            end
            if (v) begin
                e.addr = ADDRESS'(pix);
                for (int i = 0; i < SIZE; i++) e.d[i] = expv(mode, pix + offs, i);
                push(id, e);
                pix++;
            end else begin
                ngap++;
            end
            @(negedge clk);
        end
        // Hold in_valid and (optionally) start through DRAIN/DONE: both ignored.
        in_valid = 1'b1;
        start_v[id] = noise;
        chk("drain_in_ready", id, 64'(rdy[id]), 64'd0);
        chk("drain_busy", id, 64'(bsy[id]), 64'd1);
        chk("drain_done", id, 64'(dn[id]), 64'd0);
        @(negedge clk);
        chk("done_pulse", id, 64'(dn[id]), 64'd1);
        chk("done_busy", id, 64'(bsy[id]), 64'd0);
        chk("done_in_ready", id, 64'(rdy[id]), 64'd0);
        chk("done_cycle", id, 64'(cyc - t0), 64'(flen + ngap + 2));
        @(negedge clk);
        start_v[id] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("post_done", id, 64'(dn[id]), 64'd0);
            chk("post_busy", id, 64'(bsy[id]), 64'd0);
            chk("post_in_ready", id, 64'(rdy[id]), 64'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("frame_all_strobes", id, 64'(qsize(id)), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // ReLU on, shift 8, 16-bit output
        tbl[0][0] = '{32'h0000_1280, 16'h0012};
        tbl[0][1] = '{32'hFFFF_F000, 16'h0000};
        tbl[0][2] = '{32'h0080_0000, 16'h7FFF};
        tbl[0][3] = '{32'h0000_00FF, 16'h0000};
        tbl[0][4] = '{32'h007F_FFFF, 16'h7FFF};
        tbl[0][5] = '{32'h007F_FEFF, 16'h7FFE};
        tbl[0][6] = '{32'h8000_0000, 16'h0000};
        tbl[0][7] = '{32'h7FFF_FFFF, 16'h7FFF};
        tbl[0][8] = '{32'h0000_0100, 16'h0001};
        tbl[0][9] = '{32'hFFFF_FFFF, 16'h0000};
        // ReLU off, signed pass-through with floor shift and saturation
        tbl[1][0] = '{32'hFF00_0000, 16'h8000};
        tbl[1][1] = '{32'hFFFF_FE00, 16'hFFFE};
        tbl[1][2] = '{32'hFFFF_FFFF, 16'hFFFF};
        tbl[1][3] = '{32'hFF80_0000, 16'h8000};
        tbl[1][4] = '{32'hFF7F_FFFF, 16'h8000};
        tbl[1][5] = '{32'hFF80_0100, 16'h8001};
        tbl[1][6] = '{32'h0000_1280, 16'h0012};
        tbl[1][7] = '{32'h0080_0000, 16'h7FFF};
        tbl[1][8] = '{32'h0000_00FF, 16'h0000};
        tbl[1][9] = '{32'hFFFF_FF01, 16'hFFFF};

        rst = 1'b1;
        in_valid = 1'b0;
        start_v = '0;
        for (int i = 0; i < SIZE; i++) in_data[i] = '0;
        @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int id = 0; id < 3; id++) chk_rst(id);

        // Single-pixel frames with the ReLU vector table rotated across banks.
        for (int f = 0; f < 4; f++) run_frame(2, 1, 1, f * 3, 0, -1, 1'b0);
        // 16-pixel frames: signed table with gaps and stray start, then a ramp.
        run_frame(1, 16, 2, 0, 50, -1, 1'b1);
        run_frame(1, 16, 2, 5, 0, -1, 1'b0);
        run_frame(1, 16, 0, 0, 0, -1, 1'b0);
        // Full frame aborted by reset at pixel 500, then a clean full frame.
        run_frame(0, 1024, 0, 0, 0, 500, 1'b0);
        run_frame(0, 1024, 0, 0, 0, -1, 1'b0);

        repeat (2) @(negedge clk);
        for (int id = 0; id < 3; id++) chk("final_queue_empty", id, 64'(qsize(id)), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
